// File: rtl/demux_pkg.sv
// Shared constants, FSM state type and slot-to-bit mapping for the 16-way
// serial-to-parallel deserializer.
package demux_pkg;

   localparam int NUM_SLOTS = 16;
   localparam int SLOT_W    = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   // Slot k of a frame lands in bit k (LSB first) or bit 15-k (MSB first).
   function automatic logic [SLOT_W-1:0] map_slot(input logic [SLOT_W-1:0] slot,
                                                  input bit lsb_first);
      return lsb_first ? slot : SLOT_W'(NUM_SLOTS - 1) - slot;
   endfunction

endpackage

// File: rtl/demux16_deserializer_if.sv
// Bit-side and word-side handshake bundle of the deserializer; the slave
// modport is the block itself, the master modport is whoever drives it.
interface demux16_deserializer_if;
   import demux_pkg::*;

   logic                  bit_in;
   logic                  bit_valid;
   logic                  sof;
   logic                  bit_ready;
   logic [NUM_SLOTS-1:0]  out_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [SLOT_W-1:0]     slot;
   logic                  busy;
   logic                  frame_err;

   modport slave (
      input  bit_in, bit_valid, sof, out_ready,
      output bit_ready, out_data, out_valid, slot, busy, frame_err
   );

   modport master (
      output bit_in, bit_valid, sof, out_ready,
      input  bit_ready, out_data, out_valid, slot, busy, frame_err
   );

endinterface

// File: rtl/demux_1to16_dec.sv
// 4-to-16 one-hot write-enable decoder: the structural mirror of the 16:1
// mux tree on the transmit side (we == en << sel).
module demux_1to16_dec
   import demux_pkg::*;
(
   input  logic [SLOT_W-1:0]    sel,
   input  logic                 en,
   output logic [NUM_SLOTS-1:0] we
);

   // NOTE: every signal written in always_comb gets a default first; a path
   // that leaves it unassigned would otherwise infer a latch.
   always_comb begin
      we      = '0;
      we[sel] = en;
   end

endmodule

// File: rtl/demux16_deserializer.sv
// Serial-to-parallel deserializer: steers one bit per handshake into one of
// 16 word positions and presents the finished word on a valid/ready port.
module demux16_deserializer
   import demux_pkg::*;
#(
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   demux16_deserializer_if.slave bus
);

   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);

   state_t                r_state;
   state_t                w_state_nxt;
   logic [SLOT_W-1:0]     r_cnt;
   logic [SLOT_W-1:0]     w_cnt_nxt;
   logic [NUM_SLOTS-1:0]  r_shreg;
   logic [NUM_SLOTS-1:0]  w_shreg_nxt;
   logic [NUM_SLOTS-1:0]  r_out_data;
   logic                  r_out_valid;
   logic                  r_frame_err;

   logic                  w_accept;
   logic                  w_last;
   logic                  w_bit_ready;
   logic                  w_busy;
   logic                  w_write;
   logic                  w_complete;
   logic                  w_restart;
   logic [SLOT_W-1:0]     w_wr_slot;
   logic [SLOT_W-1:0]     w_wr_bit;
   logic [NUM_SLOTS-1:0]  w_we;

   assign w_accept = bus.bit_valid && w_bit_ready;

   // FSM state register.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // FSM next-state logic; a sof always restarts at slot 0, even on what
   // would have been the completing bit.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_write     = 1'b0;
      w_complete  = 1'b0;
      w_restart   = 1'b0;
      if (w_accept) begin
         unique case (r_state)
            IDLE: begin
               if (bus.sof) begin
                  w_state_nxt = SHIFT;
                  w_cnt_nxt   = SLOT_W'(1);
                  w_write     = 1'b1;
               end
            end
            SHIFT: begin
               w_write = 1'b1;
               if (bus.sof) begin
                  w_cnt_nxt = SLOT_W'(1);
                  w_restart = 1'b1;
               end else if (r_cnt == LAST_SLOT) begin
                  w_cnt_nxt   = '0;
                  w_state_nxt = IDLE;
                  w_complete  = 1'b1;
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // FSM outputs; only the completing bit can stall, and only while an
   // unconsumed word would be overwritten.
   always_comb begin
      w_busy      = (r_state == SHIFT);
      w_last      = w_busy && (r_cnt == LAST_SLOT);
      w_bit_ready = !(w_last && r_out_valid && !bus.out_ready);
   end

   assign w_wr_slot = bus.sof ? '0 : r_cnt;
   assign w_wr_bit  = map_slot(w_wr_slot, LSB_FIRST);

   demux_1to16_dec u_dec (
      .sel (w_wr_bit),
      .en  (w_write),
      .we  (w_we)
   );

   assign w_shreg_nxt = (r_shreg & ~w_we) | ({NUM_SLOTS{bus.bit_in}} & w_we);

   // Datapath: shift register, output word and error pulse.
   // NOTE: the shift register is reset even though each frame rewrites all
   // 16 slots; this keeps the post-reset state fully defined.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_shreg     <= '0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_shreg     <= w_shreg_nxt;
         r_frame_err <= w_restart;
         if (w_complete) begin
            r_out_data  <= w_shreg_nxt;
            r_out_valid <= 1'b1;
         end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign bus.bit_ready = w_bit_ready;
   assign bus.out_data  = r_out_data;
   assign bus.out_valid = r_out_valid;
   assign bus.slot      = r_cnt;
   assign bus.busy      = w_busy;
   assign bus.frame_err = r_frame_err;

endmodule

// File: tb/tb_demux16_deserializer.sv
// Bench for demux16_deserializer: LSB-first and MSB-first instances share one
// stimulus stream and are compared every cycle against a queue-based model.
module tb_demux16_deserializer;
   import demux_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic d_bit_in = 1'b0;
   logic d_bit_valid = 1'b0;
   logic d_sof = 1'b0;
   logic d_out_ready = 1'b0;

   int n_cmp = 0;
   int n_err = 0;
   bit cmp_en = 1'b0;

   always #5 clk = ~clk;

   demux16_deserializer_if if_l ();
   demux16_deserializer_if if_m ();

   assign if_l.bit_in    = d_bit_in;
   assign if_l.bit_valid = d_bit_valid;
   assign if_l.sof       = d_sof;
   assign if_l.out_ready = d_out_ready;
   assign if_m.bit_in    = d_bit_in;
   assign if_m.bit_valid = d_bit_valid;
   assign if_m.sof       = d_sof;
   assign if_m.out_ready = d_out_ready;

   demux16_deserializer #(.LSB_FIRST(1'b1)) u_dut_l (.clk(clk), .rst_n(rst_n), .bus(if_l));
   demux16_deserializer #(.LSB_FIRST(1'b0)) u_dut_m (.clk(clk), .rst_n(rst_n), .bus(if_m));

   logic [SLOT_W-1:0]    dec_sel = '0;
   logic                 dec_en = 1'b0;
   logic [NUM_SLOTS-1:0] dec_we;

   demux_1to16_dec u_dec (.sel(dec_sel), .en(dec_en), .we(dec_we));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model: the open frame is a queue of received bits.
   logic        m_q[$];
   logic        m_valid = 1'b0;
   logic [15:0] m_data_l = '0;
   logic [15:0] m_data_m = '0;
   logic        m_err = 1'b0;

   function automatic bit m_ready();
      return !(m_q.size() == 15 && m_valid && !d_out_ready);
   endfunction

   function automatic logic [15:0] pack(input bit lsb);
      logic [15:0] w;
      w = '0;
      for (int k = 0; k < 16; k++) begin
         if (lsb) w[k] = m_q[k];
         else     w[15-k] = m_q[k];
      end
      return w;
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         m_q.delete();
         m_valid  = 1'b0;
         m_data_l = '0;
         m_data_m = '0;
         m_err    = 1'b0;
      end else begin
         bit acc;
         acc   = d_bit_valid && m_ready();
         m_err = 1'b0;
         if (m_valid && d_out_ready) m_valid = 1'b0;
         if (acc) begin
            if (d_sof) begin
               if (m_q.size() != 0) m_err = 1'b1;
               m_q.delete();
               m_q.push_back(d_bit_in);
            end else if (m_q.size() != 0) begin
               m_q.push_back(d_bit_in);
               if (m_q.size() == 16) begin
                  m_data_l = pack(1'b1);
                  m_data_m = pack(1'b0);
                  m_valid  = 1'b1;
                  m_q.delete();
               end
            end
         end
      end
   end

   // Per-cycle comparison plus event counters for the directed tests.
   int n_ferr = 0;
   int n_vev = 0;
   logic prev_valid = 1'b0;

   always @(negedge clk) begin
      if (cmp_en) begin
         check("out_valid_l", if_l.out_valid, m_valid);
         check("out_valid_m", if_m.out_valid, m_valid);
         check("out_data_l",  if_l.out_data,  m_data_l);
         check("out_data_m",  if_m.out_data,  m_data_m);
         check("bit_ready_l", if_l.bit_ready, m_ready());
         check("bit_ready_m", if_m.bit_ready, m_ready());
         check("slot_l",      if_l.slot,      m_q.size());
         check("slot_m",      if_m.slot,      m_q.size());
         check("busy_l",      if_l.busy,      m_q.size() != 0);
         check("frame_err_l", if_l.frame_err, m_err);
         check("frame_err_m", if_m.frame_err, m_err);
         if (if_l.frame_err === 1'b1) n_ferr++;
         if (if_l.out_valid === 1'b1 && !prev_valid) n_vev++;
         prev_valid = if_l.out_valid;
      end
   end

   task automatic drive_bit(input logic b, input logic s);
      bit acc;
      acc = 1'b0;
      d_bit_in    = b;
      d_sof       = s;
      d_bit_valid = 1'b1;
      for (int i = 0; i < 64 && !acc; i++) begin
         @(negedge clk);
         acc = m_ready();
         @(posedge clk);
         #1;
      end
      if (!acc) begin
         n_cmp++;
         n_err++;
         $display("FAIL accept_timeout: got no accept, expected accept within 64 cycles");
      end
      d_bit_valid = 1'b0;
      d_sof       = 1'b0;
   endtask

   task automatic send_word(input logic [15:0] w, input int nbits, input int max_gap);
      for (int k = 0; k < nbits; k++) begin
         int g;
         g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
         repeat (g) begin
            d_bit_in = 1'($urandom);
            @(posedge clk);
            #1;
         end
         drive_bit(w[k], k == 0);
      end
   endtask

   initial begin
      // Decoder standalone: we must be exactly en << sel.
      for (int e = 0; e < 2; e++) begin
         for (int s = 0; s < 16; s++) begin
            dec_en  = 1'(e);
            dec_sel = 4'(s);
            #1;
            check("dec_we", dec_we, 16'(e) << s);
         end
      end

      repeat (2) @(posedge clk);
      #1;
      cmp_en = 1'b1;
      @(negedge clk);
      check("rst_valid", if_l.out_valid, 1'b0);
      check("rst_data",  if_l.out_data,  16'h0000);
      check("rst_slot",  if_l.slot,      4'd0);
      check("rst_busy",  if_l.busy,      1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      d_out_ready = 1'b1;

      // Back-to-back frame, then gapped frames.
      n_ferr = 0;
      send_word(16'hA5C3, 16, 0);
      @(negedge clk);
      check("t1_valid",  if_l.out_valid, 1'b1);
      check("t1_data_l", if_l.out_data,  16'hA5C3);
      check("t1_data_m", if_m.out_data,  16'hC3A5);
      @(posedge clk);
      #1;
      send_word(16'($urandom), 16, 5);
      send_word(16'hA5C3, 16, 5);
      @(negedge clk);
      check("t2_data_l", if_l.out_data, 16'hA5C3);
      check("t2_data_m", if_m.out_data, 16'hC3A5);
      check("t2_no_err", n_ferr, 0);
      @(posedge clk);
      #1;

      // Backpressure: only the completing bit of frame 2 stalls.
      d_out_ready = 1'b0;
      send_word(16'h1234, 16, 0);
      send_word(16'hFFFF, 15, 0);
      d_bit_in    = 1'b1;
      d_bit_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("bp_stall", if_l.bit_ready, 1'b0);
         check("bp_hold",  if_l.out_data,  16'h1234);
         @(posedge clk);
         #1;
      end
      d_out_ready = 1'b1;
      @(negedge clk);
      check("bp_release", if_l.bit_ready, 1'b1);
      @(posedge clk);
      #1;
      d_bit_valid = 1'b0;
      d_out_ready = 1'b0;
      @(negedge clk);
      check("bp_valid", if_l.out_valid, 1'b1);
      check("bp_data",  if_l.out_data,  16'hFFFF);
      @(posedge clk);
      #1;
      d_out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Abort: partial frame then a fresh sof.
      n_ferr = 0;
      n_vev  = 0;
      send_word(16'h5A5A, 7, 0);
      send_word(16'h00FF, 16, 0);
      repeat (2) @(negedge clk);
      #1;
      check("ab_err_cnt",   n_ferr, 1);
      check("ab_valid_cnt", n_vev,  1);
      check("ab_data_l",    if_l.out_data, 16'h00FF);
      check("ab_data_m",    if_m.out_data, 16'hFF00);
      @(posedge clk);
      #1;

      // Reset mid-frame, then stray bits without sof.
      send_word(16'hBEEF, 9, 0);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("mr_valid", if_l.out_valid, 1'b0);
      check("mr_data",  if_l.out_data,  16'h0000);
      check("mr_slot",  if_l.slot,      4'd0);
      check("mr_busy",  if_l.busy,      1'b0);
      @(posedge clk);
      #1;
      n_ferr = 0;
      for (int k = 0; k < 5; k++) drive_bit(1'b1, 1'b0);
      @(negedge clk);
      check("stray_slot", if_l.slot, 4'd0);
      check("stray_busy", if_l.busy, 1'b0);
      @(posedge clk);
      #1;
      send_word(16'h8001, 16, 0);
      @(negedge clk);
      check("stray_data", if_l.out_data, 16'h8001);
      check("stray_err",  n_ferr, 0);
      @(posedge clk);
      #1;

      // Fully random traffic, including random sof and backpressure.
      for (int c = 0; c < 3000; c++) begin
         d_bit_in    = 1'($urandom);
         d_bit_valid = 1'($urandom);
         d_sof       = ($urandom_range(0, 15) == 0);
         d_out_ready = 1'($urandom);
         @(posedge clk);
         #1;
      end
      d_bit_valid = 1'b0;
      d_sof       = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
